// File: rtl/rgb_bounce_box.sv
// Animated pattern source: a solid square that steps once per frame, bounces off the
// active-area edges and rotates its one-hot colour on every bounce.
module rgb_bounce_box #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned BOX_SIZE = 32,
    parameter int unsigned STEP     = 2,
    parameter logic [2:0]  BG_COLOR = 3'b000
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic [8:0] row_i,
    input  logic [9:0] column_i,
    input  logic       enable_i,
    output logic [2:0] rgb_o,
    output logic       bounce_o
);

    // Widened constants: X in 11 bits, Y in 10 bits, so step arithmetic cannot wrap.
    localparam logic [10:0] XMax  = 11'(H_ACTIVE - BOX_SIZE);
    localparam logic [10:0] XStep = 11'(STEP);
    localparam logic [10:0] XBox  = 11'(BOX_SIZE);
    localparam logic [10:0] HAct  = 11'(H_ACTIVE);
    localparam logic [9:0]  YMax  = 10'(V_ACTIVE - BOX_SIZE);
    localparam logic [9:0]  YStep = 10'(STEP);
    localparam logic [9:0]  YBox  = 10'(BOX_SIZE);
    localparam logic [9:0]  VAct  = 10'(V_ACTIVE);
    localparam logic [8:0]  VLast = 9'(V_ACTIVE - 1);

    logic [9:0] r_x;
    logic [8:0] r_y;
    logic       r_dir_x;
    logic       r_dir_y;
    logic [2:0] r_color;
    logic [8:0] r_row_prev;
    logic       r_bounce;

    logic        w_tick;
    logic [10:0] w_x_ext, w_x_up, w_x_dn;
    logic [9:0]  w_y_ext, w_y_up, w_y_dn;
    logic [9:0]  w_x_nxt;
    logic [8:0]  w_y_nxt;
    logic        w_dir_x_nxt, w_dir_y_nxt;
    logic        w_bounce_x, w_bounce_y;
    logic [10:0] w_col_ext;
    logic [9:0]  w_row_ext;
    logic        w_active, w_in_box;

    // Leaving the last visible row happens once per frame, inside vertical blanking.
    assign w_tick  = (r_row_prev == VLast) && (row_i != VLast);

    assign w_x_ext = {1'b0, r_x};
    assign w_x_up  = w_x_ext + XStep;
    assign w_x_dn  = w_x_ext - XStep;
    assign w_y_ext = {1'b0, r_y};
    assign w_y_up  = w_y_ext + YStep;
    assign w_y_dn  = w_y_ext - YStep;

    always_comb begin
        w_x_nxt     = r_x;
        w_dir_x_nxt = r_dir_x;
        w_bounce_x  = 1'b0;
        if (r_dir_x) begin
            if (w_x_up >= XMax) begin
                w_x_nxt     = XMax[9:0];
                w_dir_x_nxt = 1'b0;
                w_bounce_x  = 1'b1;
            end else begin
                w_x_nxt = w_x_up[9:0];
            end
        end else begin
            if (w_x_ext <= XStep) begin
                w_x_nxt     = 10'd0;
                w_dir_x_nxt = 1'b1;
                w_bounce_x  = 1'b1;
            end else begin
                w_x_nxt = w_x_dn[9:0];
            end
        end
    end

    always_comb begin
        w_y_nxt     = r_y;
        w_dir_y_nxt = r_dir_y;
        w_bounce_y  = 1'b0;
        if (r_dir_y) begin
            if (w_y_up >= YMax) begin
                w_y_nxt     = YMax[8:0];
                w_dir_y_nxt = 1'b0;
                w_bounce_y  = 1'b1;
            end else begin
                w_y_nxt = w_y_up[8:0];
            end
        end else begin
            if (w_y_ext <= YStep) begin
                w_y_nxt     = 9'd0;
                w_dir_y_nxt = 1'b1;
                w_bounce_y  = 1'b1;
            end else begin
                w_y_nxt = w_y_dn[8:0];
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_x        <= '0;
            r_y        <= '0;
            r_dir_x    <= 1'b1;
            r_dir_y    <= 1'b1;
            r_color    <= 3'b100;
            r_row_prev <= '0;
            r_bounce   <= 1'b0;
        end else begin
            r_row_prev <= row_i;
            r_bounce   <= 1'b0;
            if (w_tick && enable_i) begin
                r_x     <= w_x_nxt;
                r_y     <= w_y_nxt;
                r_dir_x <= w_dir_x_nxt;
                r_dir_y <= w_dir_y_nxt;
                // A corner hit still counts as a single bounce.
                if (w_bounce_x || w_bounce_y) begin
                    r_color  <= {r_color[0], r_color[2:1]};
                    r_bounce <= 1'b1;
                end
            end
        end
    end

    assign w_col_ext = {1'b0, column_i};
    assign w_row_ext = {1'b0, row_i};
    assign w_active  = (w_col_ext < HAct) && (w_row_ext < VAct);
    assign w_in_box  = (w_col_ext >= w_x_ext) && (w_col_ext < w_x_ext + XBox) &&
                       (w_row_ext >= w_y_ext) && (w_row_ext < w_y_ext + YBox);

    always_comb begin
        rgb_o = 3'b000;
        if (w_active) begin
            rgb_o = w_in_box ? r_color : BG_COLOR;
        end
    end

    assign bounce_o = r_bounce;

endmodule

// File: tb/tb_rgb_bounce_box.sv
// Directed bench for rgb_bounce_box: a default-size instance plus a small square-area
// instance where X and Y hit their far edges on the same frame.
module tb_rgb_bounce_box;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [8:0] row_a = '0, row_b = '0;
    logic [9:0] col_a = '0, col_b = '0;
    logic       en_a = 1'b1, en_b = 1'b0;
    logic [2:0] rgb_a, rgb_b;
    logic       bounce_a, bounce_b;

    int n_checks = 0;
    int n_fail   = 0;
    int n_pulses;

    always #10 clk = ~clk;

    rgb_bounce_box dut_a (
        .clk_i    (clk),
        .reset_i  (reset),
        .row_i    (row_a),
        .column_i (col_a),
        .enable_i (en_a),
        .rgb_o    (rgb_a),
        .bounce_o (bounce_a)
    );

    rgb_bounce_box #(
        .H_ACTIVE (64),
        .V_ACTIVE (64),
        .BOX_SIZE (8),
        .STEP     (2),
        .BG_COLOR (3'b111)
    ) dut_b (
        .clk_i    (clk),
        .reset_i  (reset),
        .row_i    (row_b),
        .column_i (col_b),
        .enable_i (en_b),
        .rgb_o    (rgb_b),
        .bounce_o (bounce_b)
    );

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // One frame boundary on both instances; outputs are sampled 1 time unit after the update edge.
    task automatic tick();
        row_a = 9'd479;
        row_b = 9'd63;
        @(posedge clk); #1;
        row_a = 9'd480;
        row_b = 9'd64;
        @(posedge clk); #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic pix_a(input string tag, input int c, input int r, input int exp);
        col_a = 10'(c);
        row_a = 9'(r);
        #1;
        check_eq(tag, int'(rgb_a), exp);
    endtask

    task automatic pix_b(input string tag, input int c, input int r, input int exp);
        col_b = 10'(c);
        row_b = 9'(r);
        #1;
        check_eq(tag, int'(rgb_b), exp);
    endtask

    task automatic one_clk();
        @(posedge clk); #1;
    endtask

    initial begin
        #1 reset = 1'b1;
        #5;
        pix_a("rst_pix_0_0", 0, 0, 3'b100);
        pix_a("rst_pix_31_31", 31, 31, 3'b100);
        pix_a("rst_pix_32_0", 32, 0, 3'b000);
        pix_a("rst_pix_700_10", 700, 10, 3'b000);
        check_eq("rst_bounce", int'(bounce_a), 0);
        check_eq("rst_x", int'(dut_a.r_x), 0);
        check_eq("rst_y", int'(dut_a.r_y), 0);
        @(negedge clk) reset = 1'b0;
        one_clk();

        tick();
        check_eq("t1_x", int'(dut_a.r_x), 2);
        check_eq("t1_y", int'(dut_a.r_y), 2);
        check_eq("t1_bounce", int'(bounce_a), 0);
        pix_a("t1_pix_1_1", 1, 1, 3'b000);
        pix_a("t1_pix_2_2", 2, 2, 3'b100);

        ticks(223);
        check_eq("t224_y", int'(dut_a.r_y), 448);
        check_eq("t224_x", int'(dut_a.r_x), 448);
        check_eq("t224_dir_y", int'(dut_a.r_dir_y), 0);
        check_eq("t224_color", int'(dut_a.r_color), 3'b010);
        check_eq("t224_bounce", int'(bounce_a), 1);
        pix_a("t224_pix_in", 448, 448, 3'b010);
        pix_a("t224_pix_row480", 448, 480, 3'b000);
        one_clk();
        check_eq("t224_bounce_end", int'(bounce_a), 0);

        tick();
        check_eq("t225_y", int'(dut_a.r_y), 446);
        check_eq("t225_x", int'(dut_a.r_x), 450);
        check_eq("t225_bounce", int'(bounce_a), 0);

        ticks(79);
        check_eq("t304_x", int'(dut_a.r_x), 608);
        check_eq("t304_y", int'(dut_a.r_y), 288);
        check_eq("t304_dir_x", int'(dut_a.r_dir_x), 0);
        check_eq("t304_color", int'(dut_a.r_color), 3'b001);
        check_eq("t304_bounce", int'(bounce_a), 1);

        ticks(303);
        check_eq("t607_x", int'(dut_a.r_x), 2);
        check_eq("t607_color", int'(dut_a.r_color), 3'b100);
        check_eq("t607_bounce", int'(bounce_a), 0);
        tick();
        check_eq("t608_x", int'(dut_a.r_x), 0);
        check_eq("t608_y", int'(dut_a.r_y), 320);
        check_eq("t608_dir_x", int'(dut_a.r_dir_x), 1);
        check_eq("t608_color", int'(dut_a.r_color), 3'b010);
        check_eq("t608_bounce", int'(bounce_a), 1);
        one_clk();
        check_eq("t608_bounce_end", int'(bounce_a), 0);

        en_a = 1'b0;
        n_pulses = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            n_pulses += int'(bounce_a);
        end
        check_eq("frz_x", int'(dut_a.r_x), 0);
        check_eq("frz_y", int'(dut_a.r_y), 320);
        check_eq("frz_color", int'(dut_a.r_color), 3'b010);
        check_eq("frz_pulses", n_pulses, 0);

        // Row jumps past the last visible row: no frame update.
        en_a = 1'b1;
        row_a = 9'd470; one_clk();
        row_a = 9'd0;   one_clk();
        row_a = 9'd5;   one_clk();
        check_eq("skip_x", int'(dut_a.r_x), 0);
        check_eq("skip_y", int'(dut_a.r_y), 320);

        row_a = 9'd200;
        @(negedge clk) reset = 1'b1;
        #1;
        check_eq("mrst_x", int'(dut_a.r_x), 0);
        check_eq("mrst_y", int'(dut_a.r_y), 0);
        check_eq("mrst_dir_x", int'(dut_a.r_dir_x), 1);
        check_eq("mrst_color", int'(dut_a.r_color), 3'b100);
        pix_a("mrst_pix_31_31", 31, 31, 3'b100);
        pix_a("mrst_pix_32_0", 32, 0, 3'b000);
        @(negedge clk) reset = 1'b0;
        tick();
        check_eq("mrst_t1_x", int'(dut_a.r_x), 2);
        check_eq("mrst_t1_y", int'(dut_a.r_y), 2);
        check_eq("mrst_t1_bounce", int'(bounce_a), 0);

        en_a = 1'b0;
        en_b = 1'b1;
        pix_b("b_pix_bg", 40, 40, 3'b111);
        pix_b("b_pix_out", 64, 0, 3'b000);
        pix_b("b_pix_box", 3, 3, 3'b100);
        ticks(27);
        check_eq("b_t27_x", int'(dut_b.r_x), 54);
        check_eq("b_t27_bounce", int'(bounce_b), 0);
        tick();
        check_eq("b_corner_x", int'(dut_b.r_x), 56);
        check_eq("b_corner_y", int'(dut_b.r_y), 56);
        check_eq("b_corner_color", int'(dut_b.r_color), 3'b010);
        check_eq("b_corner_bounce", int'(bounce_b), 1);
        one_clk();
        check_eq("b_corner_bounce_end", int'(bounce_b), 0);
        check_eq("b_corner_color_hold", int'(dut_b.r_color), 3'b010);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
